// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t   : controller FSM encoding (IDLE, RUN, DONE)
//   cnt_width : bit-counter width for a given operand width (minimum 1)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? int'($clog2(width)) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for serial_adder_ctrl.
//   start_valid/start_ready + a, b, cin : operand request channel
//   res_valid/res_ready + sum, cout     : result channel
//   busy                                : controller not idle
// master = operand producer / result consumer, slave = the adder controller.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output start_valid, a, b, cin, res_ready,
    input  start_ready, res_valid, sum, cout, busy
  );

  modport slave (
    input  start_valid, a, b, cin, res_ready,
    output start_ready, res_valid, sum, cout, busy
  );

endinterface

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational full adder built from two half adders and an OR.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic h1_sum;
  logic h1_carry;
  logic h2_carry;

  always_comb begin
    h1_sum   = a ^ b;
    h1_carry = a & b;
    sum      = h1_sum ^ cin;
    h2_carry = h1_sum & cin;
    cout     = h1_carry | h2_carry;
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller around a single full-adder cell.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_adder_ctrl_if slave modport (operand and result handshakes)
// Operands are accepted in IDLE, added LSB-first over WIDTH RUN cycles with the
// carry held in a flip-flop, and the result is held in DONE until accepted.
// All outputs are registered.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Shift right with the new sum bit entering at the MSB; written this way so
  // WIDTH = 1 needs no zero-width slice.
  always_comb begin
    sum_next            = sum_sh >> 1;
    sum_next[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      a_sh            <= '0;
      b_sh            <= '0;
      sum_sh          <= '0;
      carry           <= 1'b0;
      cnt             <= '0;
      bus.sum         <= '0;
      bus.cout        <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_sh            <= bus.a;
            b_sh            <= bus.b;
            carry           <= bus.cin;
            cnt             <= '0;
            sum_sh          <= '0;
            state           <= RUN;
            bus.start_ready <= 1'b0;
            bus.busy        <= 1'b1;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (cnt == LAST) begin
            // Result registers load on the final bit so DONE presents them
            // directly; the counter is left at LAST rather than wrapping.
            state         <= DONE;
            bus.sum       <= sum_next;
            bus.cout      <= fa_cout;
            bus.res_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state           <= IDLE;
            bus.res_valid   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.start_ready <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          bus.res_valid   <= 1'b0;
          bus.busy        <= 1'b0;
          bus.start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
